// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key expansion: latches a cipher key on start and streams
// round keys 0..10 over valid/ready, using an external shared S-box for SubWord.
module aes_key_sched_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         abort,
  output logic [31:0]  sbox_in,
  input  logic [31:0]  sbox_out,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_index,
  output logic         busy,
  output logic         done
);

  localparam int          NUM_WORDS = 4;
  localparam logic [3:0]  LAST_IDX  = 4'd10;

  typedef enum logic {ST_IDLE, ST_EMIT} state_e;

  state_e       state_q, state_d;
  logic [127:0] rk_data_q, rk_data_d;
  logic [3:0]   rk_index_q, rk_index_d;
  logic         rk_valid_q, rk_valid_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  // Word view of the current key: w_cur[3] is w0 (MSBs), w_cur[0] is w3.
  logic [NUM_WORDS-1:0][31:0] w_cur, w_nxt;
  logic [31:0]                temp;
  logic                       hs;

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  assign w_cur   = rk_data_q;
  assign sbox_in = {w_cur[0][23:0], w_cur[0][31:24]};
  assign temp    = sbox_out ^ {rcon(rk_index_q + 4'd1), 24'h0};
  assign w_nxt[NUM_WORDS-1] = w_cur[NUM_WORDS-1] ^ temp;

  // Each later word chains off the freshly computed word before it.
  for (genvar i = 0; i < NUM_WORDS-1; i++) begin : g_chain
    assign w_nxt[i] = w_cur[i] ^ w_nxt[i+1];
  end

  assign hs = rk_valid_q && rk_ready;

  always_comb begin
    state_d    = state_q;
    rk_data_d  = rk_data_q;
    rk_index_d = rk_index_q;
    rk_valid_d = rk_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    if (abort) begin
      state_d    = ST_IDLE;
      rk_valid_d = 1'b0;
      busy_d     = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d    = ST_EMIT;
            rk_data_d  = key_in;
            rk_index_d = 4'd0;
            rk_valid_d = 1'b1;
            busy_d     = 1'b1;
          end
        end
        ST_EMIT: begin
          if (hs) begin
            if (rk_index_q == LAST_IDX) begin
              state_d    = ST_IDLE;
              rk_valid_d = 1'b0;
              busy_d     = 1'b0;
              done_d     = 1'b1;
            end else begin
              rk_data_d  = w_nxt;
              rk_index_d = rk_index_q + 4'd1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rk_data_q  <= '0;
      rk_index_q <= '0;
      rk_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rk_data_q  <= rk_data_d;
      rk_index_q <= rk_index_d;
      rk_valid_q <= rk_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign rk_valid = rk_valid_q;
  assign rk_data  = rk_data_q;
  assign rk_index = rk_index_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: models the S-box in GF(2^8) and checks the
// streamed round keys against a word-array FIPS-197 key expansion.
module tb_aes_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key_in = '0;
  logic         abort = 1'b0;
  logic [31:0]  sbox_in;
  logic [31:0]  sbox_out;
  logic         rk_valid;
  logic         rk_ready = 1'b0;
  logic [127:0] rk_data;
  logic [3:0]   rk_index;
  logic         busy;
  logic         done;

  int tests = 0;
  int fails = 0;
  logic [127:0] exp_rk [0:10];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK1 = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK2 = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;

  aes_key_sched_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in), .abort(abort),
    .sbox_in(sbox_in), .sbox_out(sbox_out), .rk_valid(rk_valid),
    .rk_ready(rk_ready), .rk_data(rk_data), .rk_index(rk_index),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    if (x != 8'h00) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  assign sbox_out = sub_word(sbox_in);

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [127:0] key);
    start = 1'b1;
    key_in = key;
    step();
    start = 1'b0;
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    #1;
    tests++;
    if ({rk_valid, busy, done} !== 3'b000 || rk_data !== '0 || rk_index !== 4'd0 || sbox_in !== 32'h0) begin
      fails++;
      $display("FAIL reset: got v/b/d=%b%b%b idx=%0d data=%h, want 000 idx=0 data=0",
               rk_valid, busy, done, rk_index, rk_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  // rk_ready held high: index k appears k cycles after the start is seen, done one after 10.
  task automatic test_ready_high(input logic [127:0] key, input bit fips);
    expand(key);
    rk_ready = 1'b1;
    do_start(key);
    for (int k = 0; k <= 10; k++) begin
      tests++;
      if (rk_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || rk_index !== 4'(k) || rk_data !== exp_rk[k]) begin
        fails++;
        $display("FAIL stream_k%0d: got v=%b idx=%0d data=%h, want v=1 idx=%0d data=%h",
                 k, rk_valid, rk_index, rk_data, k, exp_rk[k]);
      end
      if (fips && k == 1) begin
        tests++;
        if (rk_data !== FIPS_RK1) begin
          fails++; $display("FAIL fips_rk1: got %h want %h", rk_data, FIPS_RK1);
        end
      end
      if (fips && k == 10) begin
        tests++;
        if (rk_data !== FIPS_RK10) begin
          fails++; $display("FAIL fips_rk10: got %h want %h", rk_data, FIPS_RK10);
        end
      end
      if (!fips && k == 1) begin
        tests++;
        if (rk_data !== ZERO_RK1) begin
          fails++; $display("FAIL zero_rk1: got %h want %h", rk_data, ZERO_RK1);
        end
      end
      if (!fips && k == 2) begin
        tests++;
        if (rk_data !== ZERO_RK2) begin
          fails++; $display("FAIL zero_rk2: got %h want %h", rk_data, ZERO_RK2);
        end
      end
      step();
    end
    tests++;
    if (done !== 1'b1 || rk_valid !== 1'b0 || busy !== 1'b0 || rk_index !== 4'd10 || rk_data !== exp_rk[10]) begin
      fails++;
      $display("FAIL done_t12: got d=%b v=%b b=%b idx=%0d, want d=1 v=0 b=0 idx=10",
               done, rk_valid, busy, rk_index);
    end
    step();
    tests++;
    if (done !== 1'b0) begin
      fails++; $display("FAIL done_pulse: got done=%b want 0", done);
    end
  endtask

  // Random rk_ready; optionally fire stray starts with junk keys while busy.
  task automatic run_bp(input logic [127:0] key, input bit poke_start, input string name);
    logic [127:0] pdata = '0;
    logic [3:0]   pidx = '0;
    bit           stalled = 1'b0;
    int           nacc = 0;
    int           cyc = 0;
    expand(key);
    rk_ready = 1'b0;
    do_start(key);
    while (done !== 1'b1 && cyc < 400) begin
      rk_ready = 1'($urandom_range(0, 1));
      if (poke_start) begin
        start = 1'($urandom_range(0, 1));
        key_in = rand_key();
      end
      if (stalled) begin
        tests++;
        if (rk_data !== pdata || rk_index !== pidx) begin
          fails++;
          $display("FAIL %s_stall: got idx=%0d data=%h, want idx=%0d data=%h",
                   name, rk_index, rk_data, pidx, pdata);
        end
      end
      if (rk_valid === 1'b1 && rk_ready) begin
        tests++;
        if (nacc > 10 || rk_index !== 4'(nacc) || rk_data !== exp_rk[nacc]) begin
          fails++;
          $display("FAIL %s_accept%0d: got idx=%0d data=%h, want idx=%0d data=%h",
                   name, nacc, rk_index, rk_data, nacc, exp_rk[nacc > 10 ? 10 : nacc]);
        end
        nacc++;
      end
      stalled = (rk_valid === 1'b1) && !rk_ready;
      pdata = rk_data;
      pidx = rk_index;
      step();
      cyc++;
    end
    start = 1'b0;
    tests++;
    if (done !== 1'b1 || nacc != 11) begin
      fails++;
      $display("FAIL %s_complete: got done=%b accepted=%0d, want done=1 accepted=11", name, done, nacc);
    end
    step();
  endtask

  task automatic test_abort();
    logic [127:0] key = rand_key();
    int cyc = 0;
    expand(key);
    do_start(key);
    while (!(rk_valid === 1'b1 && rk_index === 4'd4) && cyc < 200) begin
      rk_ready = 1'($urandom_range(0, 1));
      step();
      cyc++;
    end
    rk_ready = 1'b0;
    step();
    tests++;
    if (rk_index !== 4'd4 || rk_data !== exp_rk[4] || rk_valid !== 1'b1) begin
      fails++;
      $display("FAIL abort_reach4: got v=%b idx=%0d, want v=1 idx=4", rk_valid, rk_index);
    end
    abort = 1'b1;
    rk_ready = 1'b1;
    step();
    abort = 1'b0;
    tests++;
    if (rk_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL abort_next: got v=%b b=%b d=%b, want 000", rk_valid, busy, done);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      tests++;
      if (rk_valid !== 1'b0 || done !== 1'b0) begin
        fails++;
        $display("FAIL abort_idle%0d: got v=%b d=%b, want 00", i, rk_valid, done);
      end
    end
    run_bp(rand_key(), 1'b0, "restart");
  endtask

  task automatic test_start_abort_idle();
    start = 1'b1;
    abort = 1'b1;
    key_in = rand_key();
    step();
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (rk_valid !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL start_abort%0d: got v=%b b=%b, want 00", i, rk_valid, busy);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] ka = rand_key();
    logic [127:0] kb = rand_key();
    expand(ka);
    rk_ready = 1'b1;
    do_start(ka);
    for (int i = 0; i < 11; i++) step();
    tests++;
    if (done !== 1'b1) begin
      fails++; $display("FAIL b2b_done: got done=%b want 1", done);
    end
    expand(kb);
    do_start(kb);
    tests++;
    if (rk_valid !== 1'b1 || rk_index !== 4'd0 || rk_data !== kb) begin
      fails++;
      $display("FAIL b2b_restart: got v=%b idx=%0d data=%h, want v=1 idx=0 data=%h",
               rk_valid, rk_index, rk_data, kb);
    end
    for (int i = 0; i < 10; i++) step();
    tests++;
    if (rk_index !== 4'd10 || rk_data !== exp_rk[10]) begin
      fails++;
      $display("FAIL b2b_rk10: got idx=%0d data=%h, want idx=10 data=%h", rk_index, rk_data, exp_rk[10]);
    end
    step();
    step();
  endtask

  task automatic test_async_reset();
    rk_ready = 1'b1;
    do_start(rand_key());
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({rk_valid, busy, done} !== 3'b000 || rk_data !== '0 || rk_index !== 4'd0 || sbox_in !== 32'h0) begin
      fails++;
      $display("FAIL async_reset: got v/b/d=%b%b%b idx=%0d data=%h, want 000 idx=0 data=0",
               rk_valid, busy, done, rk_index, rk_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    tests++;
    if (rk_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_idle: got v=%b b=%b, want 00", rk_valid, busy);
    end
  endtask

  initial begin
    test_reset();
    test_ready_high(FIPS_KEY, 1'b1);
    test_ready_high(128'h0, 1'b0);
    run_bp(FIPS_KEY, 1'b0, "bp_fips");
    for (int i = 0; i < 3; i++) run_bp(rand_key(), 1'b0, "bp_rand");
    run_bp(rand_key(), 1'b1, "busy_start");
    test_abort();
    test_start_abort_idle();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aes_key_sched_ctrl.md
# aes_key_sched_ctrl

Iterative AES-128 key-expansion controller. On a start pulse it latches a 128-bit cipher key and emits the 11 round keys (index 0..10) in order over a valid/ready stream, one key per accepted handshake. It sequences round-constant selection internally and drives a shared, externally instantiated 4-byte S-box for SubWord. It sits between the key-load interface and the round datapath, so the datapath consumes round keys on demand instead of storing all 11.

## Interface
- No parameters. AES-128 only: Nk=4, 10 rounds.
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request to begin expansion; sampled only in IDLE
- key_in  in  128  cipher key, sampled on the accepted start cycle; word w0 = key_in[127:96]
- abort  in  1  returns the block to IDLE next cycle; has priority over start
- sbox_in  out  32  RotWord(w3) of the current round key, to the shared S-box
- sbox_out  in  32  combinational S-box result for sbox_in (bytewise SubBytes)
- rk_valid  out  1  round key on rk_data is valid
- rk_ready  in  1  consumer accepts the round key
- rk_data  out  128  current round key {w0,w1,w2,w3}
- rk_index  out  4  round number of rk_data, 0..10
- busy  out  1  high in EMIT
- done  out  1  one-cycle pulse after round key 10 is accepted

## Operation
- States: IDLE, EMIT.
- IDLE: rk_valid=0, busy=0. If start=1 and abort=0: rk_data<=key_in, rk_index<=0, go to EMIT.
- EMIT: rk_valid=1, busy=1. rk_data and rk_index hold while rk_valid=1 and rk_ready=0.
- On a handshake (rk_valid and rk_ready) with rk_index<10, register the next key and set rk_index<=rk_index+1. Next-key logic:
  - temp = sbox_out ^ {rcon(rk_index+1), 24'h0}
  - w4=w0^temp; w5=w1^w4; w6=w2^w5; w7=w3^w6
- Round constants: rcon(1..10) = 01,02,04,08,10,20,40,80,1b,36 (hex). Any other index gives 00, but only indices 1..10 can occur.
- sbox_in = {w3[23:0], w3[31:24]} continuously from the registered rk_data, including in IDLE.
- On a handshake with rk_index=10: go to IDLE and pulse done=1 for one cycle. rk_data and rk_index keep their last values.
- abort=1 in any state: next state IDLE, rk_valid=0, done=0. No handshake completes in the abort cycle's successor.
- start while busy is ignored.
- All arithmetic is bitwise XOR. rk_index never wraps past 10.

## Timing
- Reset values (async, immediate): state IDLE, rk_valid=0, rk_data=0, rk_index=0, busy=0, done=0.
- Start accepted at cycle T: rk_valid=1 with rk_index=0 at T+1.
- With rk_ready tied high: indices 0..10 appear on cycles T+1..T+11, and done=1 at T+12.
- No combinational path from rk_ready to rk_valid or rk_data.
- The only combinational input-to-output path is none. The sbox_in → sbox_out → next-key path is one register stage.
- A new start is accepted on the cycle done is high, because the state is already IDLE.
- Reset asserted mid-EMIT clears everything asynchronously. After release the block sits in IDLE awaiting start.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1:
  - index 0 = key
  - index 1 = a0fafe1788542cb123a339392a6c7605
  - index 10 = d014f9a8c9ee2589e13f0cc8b6630ca6
  - done at T+12
- All-zero key: index 1 = 62636363626363636263636362636363; index 2 = 9b9898c9f9fbfbaa9b9898c9f9fbfbaa.
- Backpressure: rk_ready random ~50%. The sequence of accepted keys must be identical to the rk_ready=1 run, and rk_data/rk_index must be stable throughout every stall.
- Abort at rk_index=4 while stalled:
  - rk_valid=0 next cycle, and no done pulse.
  - A fresh start then restarts at index 0 with the new key.
- Start pulses while busy have no effect. Start and abort in the same IDLE cycle leave the block in IDLE.
- rst_n pulsed low mid-EMIT: all outputs read reset values immediately, with no dependence on a clock edge.
